// File: rtl/bus_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bus_wait_ctrl
//  Purpose  : 6502 bus-cycle sequencer: ROM/I/O wait states and SDRAM req/ack
//             stall. Optional SDRAM handshake timeout under BUS_TIMEOUT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module bus_wait_ctrl #(
  parameter int ROM_WS_DEFAULT = 1,
  parameter int IO_WS_DEFAULT  = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_cpu_valid,
  input  logic       i_rom_cs,
  input  logic       i_io_cs,
  input  logic       i_sdram_cs,
  input  logic       i_sdram_ack,
  input  logic       i_cfg_we,
  input  logic [7:0] i_cfg_data,
  input  logic       i_timeout_clr,
  output logic       o_rdy,
  output logic       o_sdram_req,
  output logic       o_timeout,
  output logic [7:0] o_ws_cfg
);

  localparam logic [1:0] c_S_IDLE = 2'd0;
  localparam logic [1:0] c_S_WAIT = 2'd1;
  localparam logic [1:0] c_S_SREQ = 2'd2;

  localparam logic [7:0] c_CFG_RST = {4'(IO_WS_DEFAULT), 4'(ROM_WS_DEFAULT)};

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic [3:0] r_cnt;
  logic [3:0] w_cnt_nxt;
  logic [7:0] r_ws_cfg;
  logic       r_sdram_req;
  logic       w_sdram_req_nxt;
  logic [3:0] w_ws_sel;
  logic       w_expire;

  // Wait count of the highest-priority selected target; SDRAM uses the handshake instead.
  always_comb begin
    w_ws_sel = 4'd0;
    if (i_sdram_cs)
      w_ws_sel = 4'd0;
    else if (i_rom_cs)
      w_ws_sel = r_ws_cfg[3:0];
    else if (i_io_cs)
      w_ws_sel = r_ws_cfg[7:4];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= c_S_IDLE;
      r_cnt       <= 4'd0;
      r_sdram_req <= 1'b0;
      r_ws_cfg    <= c_CFG_RST;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_sdram_req <= w_sdram_req_nxt;
      if (i_cfg_we)
        r_ws_cfg <= i_cfg_data;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_sdram_req_nxt = r_sdram_req;
    case (r_state)
      c_S_IDLE: begin
        if (i_cpu_valid) begin
          if (i_sdram_cs) begin
            w_state_nxt     = c_S_SREQ;
            w_sdram_req_nxt = 1'b1;
          end else if (w_ws_sel >= 4'd2) begin
            // The valid cycle already counts as the first wait state.
            w_state_nxt = c_S_WAIT;
            w_cnt_nxt   = w_ws_sel - 4'd1;
          end
        end
      end
      c_S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt <= 4'd1)
          w_state_nxt = c_S_IDLE;
      end
      c_S_SREQ: begin
        if (i_sdram_ack || w_expire) begin
          w_state_nxt     = c_S_IDLE;
          w_sdram_req_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt     = c_S_IDLE;
        w_sdram_req_nxt = 1'b0;
      end
    endcase
  end

  always_comb begin
    o_rdy = 1'b1;
    if (!i_rst) begin
      case (r_state)
        c_S_IDLE: o_rdy = !(i_cpu_valid && (i_sdram_cs || (w_ws_sel != 4'd0)));
        default:  o_rdy = 1'b0;
      endcase
    end
  end

  assign o_sdram_req = r_sdram_req;
  assign o_ws_cfg    = r_ws_cfg;

`ifdef BUS_TIMEOUT_EN
  localparam int c_TO_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(TIMEOUT_CYCLES - 1);

  logic [c_TO_W-1:0] r_to_cnt;
  logic              r_timeout;

  // Counts completed SREQ cycles; an ack on the last allowed cycle still wins.
  assign w_expire = (r_state == c_S_SREQ) && (r_to_cnt == c_TO_LAST) && !i_sdram_ack;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (r_state == c_S_SREQ)
        r_to_cnt <= r_to_cnt + 1'b1;
      else
        r_to_cnt <= '0;
      if (w_expire)
        r_timeout <= 1'b1;
      else if (i_timeout_clr)
        r_timeout <= 1'b0;
    end
  end

  assign o_timeout = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = &{1'b0, i_timeout_clr, (TIMEOUT_CYCLES > 0)};
  assign w_expire    = 1'b0;
  assign o_timeout   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bus_wait_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bus_wait_ctrl
//  Purpose  : Self-checking bench for bus_wait_ctrl against a transaction model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_wait_ctrl;

  localparam int c_T = 8;
  localparam logic [7:0] c_CFG_DEF = 8'h01;

  logic       clk = 1'b0;
  logic       i_rst = 1'b1;
  logic       i_cpu_valid = 1'b0;
  logic       i_rom_cs = 1'b0;
  logic       i_io_cs = 1'b0;
  logic       i_sdram_cs = 1'b0;
  logic       i_sdram_ack = 1'b0;
  logic       i_cfg_we = 1'b0;
  logic [7:0] i_cfg_data = 8'h00;
  logic       i_timeout_clr = 1'b0;
  logic       o_rdy;
  logic       o_sdram_req;
  logic       o_timeout;
  logic [7:0] o_ws_cfg;

  always #5 clk = ~clk;

  bus_wait_ctrl #(
    .ROM_WS_DEFAULT(1),
    .IO_WS_DEFAULT (0),
    .TIMEOUT_CYCLES(c_T)
  ) dut (
    .i_clk        (clk),
    .i_rst        (i_rst),
    .i_cpu_valid  (i_cpu_valid),
    .i_rom_cs     (i_rom_cs),
    .i_io_cs      (i_io_cs),
    .i_sdram_cs   (i_sdram_cs),
    .i_sdram_ack  (i_sdram_ack),
    .i_cfg_we     (i_cfg_we),
    .i_cfg_data   (i_cfg_data),
    .i_timeout_clr(i_timeout_clr),
    .o_rdy        (o_rdy),
    .o_sdram_req  (o_sdram_req),
    .o_timeout    (o_timeout),
    .o_ws_cfg     (o_ws_cfg)
  );

  int         checks = 0;
  int         errors = 0;
  logic [7:0] m_cfg = c_CFG_DEF;
  logic       m_to = 1'b0;
  int         g_clr_pct = 15;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic sample(input logic e_rdy, input logic e_req, input string tag);
    @(negedge clk);
    chk({tag, "_rdy"}, 32'(o_rdy), 32'(e_rdy));
    chk({tag, "_req"}, 32'(o_sdram_req), 32'(e_req));
    chk({tag, "_cfg"}, 32'(o_ws_cfg), 32'(m_cfg));
    chk({tag, "_to"}, 32'(o_timeout), 32'(m_to));
  endtask

  task automatic next_edge;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    i_cpu_valid   = 1'b0;
    i_rom_cs      = 1'b0;
    i_io_cs       = 1'b0;
    i_sdram_cs    = 1'b0;
    i_sdram_ack   = 1'b0;
    i_cfg_we      = 1'b0;
    i_timeout_clr = 1'b0;
  endtask

  // One CPU access. The model states the outcome as stall length L (rdy low for
  // cycles 0..L-1) and SDRAM request window 1..E; ack_d=0 means "never ack".
  task automatic do_access(input bit rom, input bit io, input bit sd, input bit we,
                           input logic [7:0] wd, input int ack_d, input string tag);
    int L;
    int E;
    bit to_set;
    to_set = 1'b0;
    E      = ack_d;
`ifdef BUS_TIMEOUT_EN
    if (sd && (ack_d == 0 || ack_d > c_T)) begin
      to_set = 1'b1;
      E      = c_T;
    end
`endif
    if (sd)
      L = E + 1;
    else if (rom)
      L = int'(m_cfg[3:0]);
    else if (io)
      L = int'(m_cfg[7:4]);
    else
      L = 0;
    for (int c = 0; c <= L; c++) begin
      i_cpu_valid   = (c == 0);
      i_rom_cs      = (c == 0) && rom;
      i_io_cs       = (c == 0) && io;
      i_sdram_cs    = (c == 0) && sd;
      i_cfg_we      = (c == 0) ? we : ($urandom_range(0, 7) == 0);
      i_cfg_data    = (c == 0) ? wd : 8'($urandom);
      if (sd && c >= 1 && c <= E)
        i_sdram_ack = (c == E) && !to_set;
      else
        i_sdram_ack = ($urandom_range(0, 3) == 0);
      i_timeout_clr = ($urandom_range(0, 99) < g_clr_pct);
      sample(c >= L, sd && c >= 1 && c <= E, tag);
      if (i_cfg_we)
        m_cfg = i_cfg_data;
      if (to_set && c == E)
        m_to = 1'b1;
      else if (i_timeout_clr)
        m_to = 1'b0;
      next_edge;
    end
    idle_inputs;
  endtask

  // Starts an access, lets it stall a few cycles, then resets mid-flight.
  task automatic reset_mid(input bit sd, input string tag);
    i_cpu_valid = 1'b1;
    i_rom_cs    = !sd;
    i_sdram_cs  = sd;
    sample(1'b0, 1'b0, tag);
    next_edge;
    idle_inputs;
    for (int c = 1; c <= 3; c++) begin
      sample(1'b0, sd, tag);
      next_edge;
    end
    i_rst       = 1'b1;
    i_cpu_valid = 1'b1;
    i_sdram_cs  = 1'b1;
    sample(1'b1, sd, {tag, "_inrst"});
    m_cfg = c_CFG_DEF;
    m_to  = 1'b0;
    next_edge;
    i_rst = 1'b0;
    idle_inputs;
    sample(1'b1, 1'b0, {tag, "_after"});
    next_edge;
  endtask

  initial begin
    // Reset held with a pending SDRAM access: rdy must stay high.
    i_cpu_valid = 1'b1;
    i_sdram_cs  = 1'b1;
    next_edge;
    sample(1'b1, 1'b0, "reset");
    next_edge;
    i_rst = 1'b0;
    idle_inputs;
    g_clr_pct = 0;

    do_access(1, 0, 0, 0, 8'h00, 0, "rom_def");
    do_access(0, 0, 0, 1, 8'h35, 0, "cfg35");
    do_access(1, 0, 0, 0, 8'h00, 0, "rom5");
    do_access(0, 1, 0, 0, 8'h00, 0, "io3");
    do_access(0, 0, 0, 0, 8'h00, 0, "nocs");
    do_access(1, 1, 1, 0, 8'h00, 4, "sdram4");
    do_access(0, 1, 0, 1, 8'hF0, 0, "io_oldcfg");
    do_access(0, 1, 0, 0, 8'h00, 0, "io15");
    do_access(0, 0, 0, 1, 8'h0A, 0, "cfg0a");
    reset_mid(1'b0, "rst_wait");
    reset_mid(1'b1, "rst_sreq");

`ifdef BUS_TIMEOUT_EN
    do_access(0, 0, 1, 0, 8'h00, 0, "tmo");
    do_access(0, 0, 0, 0, 8'h00, 0, "tmo_hold");
    i_timeout_clr = 1'b1;
    sample(1'b1, 1'b0, "tmo_clr");
    m_to = 1'b0;
    next_edge;
    idle_inputs;
    sample(1'b1, 1'b0, "tmo_cleared");
    next_edge;
    do_access(0, 0, 1, 0, 8'h00, c_T, "ack_last");
`endif

    g_clr_pct = 15;
    for (int n = 0; n < 150; n++) begin
      int sel;
      int ad;
      sel = $urandom_range(0, 7);
`ifdef BUS_TIMEOUT_EN
      ad = $urandom_range(0, c_T + 2);
`else
      ad = $urandom_range(1, 12);
`endif
      do_access(sel[0], sel[1], sel[2], ($urandom_range(0, 3) == 0), 8'($urandom), ad, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
